quadrant_selector_seq: RTL and testbench



---
 rtl/qsel_pkg.sv | 60 ++++++
 rtl/qsel_coef_rom.sv | 26 ++
 rtl/quadrant_selector_seq.sv | 201 ++++++++++++++++++++
 tb/tb_quadrant_selector_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qsel_pkg.sv
// Shared types and elaboration-time helpers for the quadrant selector.
package qsel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Cycles spent after the last channel issue while the pipeline empties.
    localparam int DRAIN_CYCLES = 3;

    // Segment-centre coefficient, unsigned Q0.w, clamped to 2^w-1.
    // sin is evaluated by Taylor series so the table can be built at
    // elaboration time; cos(phi) is taken as sin(pi/2 - phi).
    function automatic longint unsigned coef_calc(input int seg, input int w,
                                                  input int seg_bits, input bit is_sin);
        real    pi;
        real    phi;
        real    x;
        real    term;
        real    sum;
        real    scale;
        longint r;
        longint max_v;
        pi    = 3.14159265358979323846;
        phi   = real'(2 * seg + 1) * (pi / 2.0) / real'(2 * (1 << seg_bits));
        x     = is_sin ? phi : (pi / 2.0 - phi);
        sum   = x;
        term  = x;
        for (int i = 1; i <= 10; i++) begin
            term = -term * x * x / real'((2 * i) * (2 * i + 1));
            sum  = sum + term;
        end
        scale = 1.0;
        for (int i = 0; i < w; i++) begin
            scale = scale * 2.0;
        end
        // real-to-integer cast rounds to nearest
        r     = longint'(sum * scale);
        max_v = (longint'(1) << w) - 1;
        if (r > max_v) r = max_v;
        if (r < 0) r = 0;
        return longint'(r);
    endfunction

    // Clamp a sign-extended value to the signed range of a w-bit word (w <= 32).
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] res;
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (w - 1));
        res = v;
        if (v > hi) res = hi;
        if (v < lo) res = lo;
        return res;
    endfunction

endpackage

// File: rtl/qsel_coef_rom.sv
// Segment weighting table: seg -> {S, C} at the segment centre angle.
module qsel_coef_rom import qsel_pkg::*; #(
    parameter int W        = 16,
    parameter int SEG_BITS = 2
) (
    input  logic [SEG_BITS-1:0] seg,
    output logic [W-1:0]        s_coef,
    output logic [W-1:0]        c_coef
);

    localparam int N_SEG = 1 << SEG_BITS;

    logic [W-1:0] s_tab [N_SEG];
    logic [W-1:0] c_tab [N_SEG];

    for (genvar g = 0; g < N_SEG; g++) begin : g_seg
        localparam logic [W-1:0] S_VAL = W'(coef_calc(g, W, SEG_BITS, 1'b1));
        localparam logic [W-1:0] C_VAL = W'(coef_calc(g, W, SEG_BITS, 1'b0));
        assign s_tab[g] = S_VAL;
        assign c_tab[g] = C_VAL;
    end

    assign s_coef = s_tab[seg];
    assign c_coef = c_tab[seg];

endmodule

// File: rtl/quadrant_selector_seq.sv
// Snapshot resolver sin/cos and read-counter angles on start, then sweep the
// channels through a 3-stage rotate / multiply / shift-saturate pipeline.
// Output handshake: err_valid is a pure valid strobe with no ready; when high,
// err_ch/err_data describe one channel result for that single cycle only.
module quadrant_selector_seq import qsel_pkg::*; #(
    parameter int N_CH     = 5,
    parameter int W        = 16,
    parameter int CW       = 16,
    parameter int SEG_BITS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [N_CH*W-1:0]        sin_in,
    input  logic [N_CH*W-1:0]        cos_in,
    input  logic [N_CH*CW-1:0]       ang_in,
    output logic                     busy,
    output logic                     err_valid,
    output logic [$clog2(N_CH)-1:0]  err_ch,
    output logic signed [W-1:0]      err_data,
    output logic                     done,
    output logic                     overrun
);

    localparam int CH_W  = $clog2(N_CH);
    localparam int CNT_W = $clog2((N_CH > DRAIN_CYCLES) ? N_CH : DRAIN_CYCLES + 1);
    localparam int PW    = 2 * W + 2;
    localparam int DW    = PW + 1;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic                issue, accept;

    logic [N_CH*W-1:0]   sin_q, cos_q;
    logic [N_CH*CW-1:0]  ang_q;

    logic signed [W-1:0] s_raw, c_raw;
    logic [1:0]          quad;
    logic [SEG_BITS-1:0] seg;
    logic signed [W:0]   s_ext, c_ext, rs, rc;
    logic [W-1:0]        s_coef, c_coef;

    logic                v1, v2;
    logic [CH_W-1:0]     ch1, ch2;
    logic signed [W:0]   rs1, rc1;
    logic [W-1:0]        sc1, cc1;
    logic signed [PW-1:0] p1_nx, p2_nx, p1, p2;
    logic signed [DW-1:0] diff, shifted;

    // FSM state and channel/drain counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // FSM next state: IDLE -> SWEEP (one channel per cycle) -> DRAIN -> IDLE
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        issue    = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = SWEEP;
                    cnt_nx   = '0;
                end
            end
            SWEEP: begin
                issue = 1'b1;
                if (cnt == CNT_W'(N_CH - 1)) begin
                    state_nx = DRAIN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // Input snapshot, taken only on an accepted start
    always_ff @(posedge clk) begin
        if (accept) begin
            sin_q <= sin_in;
            cos_q <= cos_in;
            ang_q <= ang_in;
        end
    end

    assign s_raw = sin_q[int'(cnt) * W +: W];
    assign c_raw = cos_q[int'(cnt) * W +: W];
    assign quad  = ang_q[int'(cnt) * CW + CW - 2 +: 2];
    assign seg   = ang_q[int'(cnt) * CW + CW - 2 - SEG_BITS +: SEG_BITS];

    // Quadrant rotation in W+1 bits so negating the most negative sample is exact
    always_comb begin
        s_ext = {s_raw[W-1], s_raw};
        c_ext = {c_raw[W-1], c_raw};
        case (quad)
            2'd0:    begin rs = s_ext;  rc = c_ext;  end
            2'd1:    begin rs = -c_ext; rc = s_ext;  end
            2'd2:    begin rs = -s_ext; rc = -c_ext; end
            default: begin rs = c_ext;  rc = -s_ext; end
        endcase
    end

    qsel_coef_rom #(.W(W), .SEG_BITS(SEG_BITS)) u_rom (
        .seg    (seg),
        .s_coef (s_coef),
        .c_coef (c_coef)
    );

    // Stage 1: rotated samples and segment coefficients
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
        end else begin
            v1 <= issue;
            if (issue) begin
                rs1 <= rs;
                rc1 <= rc;
                sc1 <= s_coef;
                cc1 <= c_coef;
                ch1 <= CH_W'(cnt);
            end
        end
    end

    // Signed (W+1) x unsigned W products, all operands widened to PW first
    always_comb begin
        p1_nx = PW'(rs1) * PW'($signed({1'b0, cc1}));
        p2_nx = PW'(rc1) * PW'($signed({1'b0, sc1}));
    end

    // Stage 2: product registers
    always_ff @(posedge clk) begin
        if (rst) begin
            v2 <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                p1  <= p1_nx;
                p2  <= p2_nx;
                ch2 <= ch1;
            end
        end
    end

    // Difference and floor-shift back to sample scale
    always_comb begin
        diff    = DW'(p1) - DW'(p2);
        shifted = diff >>> W;
    end

    // Stage 3: saturated error word, done on the last channel
    always_ff @(posedge clk) begin
        if (rst) begin
            err_valid <= 1'b0;
            done      <= 1'b0;
            err_ch    <= '0;
            err_data  <= '0;
        end else begin
            err_valid <= v2;
            done      <= v2 && (ch2 == CH_W'(N_CH - 1));
            if (v2) begin
                err_ch   <= ch2;
                err_data <= W'(sat_w(64'(shifted), W));
            end
        end
    end

    // A start that arrives while busy is dropped and flagged one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else begin
            overrun <= start && (state != IDLE);
        end
    end

endmodule

// File: tb/tb_quadrant_selector_seq.sv
// Scoreboard bench for quadrant_selector_seq: driver pushes expected results
// from a behavioural model, a negedge monitor pops and compares.
module tb_quadrant_selector_seq;

    localparam int N_CH     = 5;
    localparam int W        = 16;
    localparam int CW       = 16;
    localparam int SEG_BITS = 2;
    localparam int CH_W     = 3;
    localparam int EXP_W    = 53;  // {cycle[52:21], near0[20], done[19], ch[18:16], data[15:0]}

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic [N_CH*W-1:0]       sin_in = '0;
    logic [N_CH*W-1:0]       cos_in = '0;
    logic [N_CH*CW-1:0]      ang_in = '0;
    logic                    busy, err_valid, done, overrun;
    logic [CH_W-1:0]         err_ch;
    logic signed [W-1:0]     err_data;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   acc_t = -1000;
    int   ov_cyc = -1;
    bit   checking = 1'b0;
    logic [EXP_W-1:0] exp_q[$];

    int   vs[N_CH];
    int   vc[N_CH];
    int   va[N_CH];
    bit   sm[N_CH];

    quadrant_selector_seq #(.N_CH(N_CH), .W(W), .CW(CW), .SEG_BITS(SEG_BITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sin_in    (sin_in),
        .cos_in    (cos_in),
        .ang_in    (ang_in),
        .busy      (busy),
        .err_valid (err_valid),
        .err_ch    (err_ch),
        .err_data  (err_data),
        .done      (done),
        .overrun   (overrun)
    );

    // clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: rotate by quadrant, weight by segment-centre sin/cos, floor, clamp.
    function automatic int model_err(input int s, input int c, input int ang);
        int     s_tab[4] = '{12785, 36410, 54491, 64277};
        int     c_tab[4] = '{64277, 54491, 36410, 12785};
        int     q, sg, rs, rc;
        longint d;
        q  = (ang / 16384) % 4;
        sg = (ang / 4096) % 4;
        case (q)
            0:       begin rs = s;  rc = c;  end
            1:       begin rs = -c; rc = s;  end
            2:       begin rs = -s; rc = -c; end
            default: begin rs = c;  rc = -s; end
        endcase
        d = longint'(rs) * c_tab[sg] - longint'(rc) * s_tab[sg];
        if (d >= 0) d = d / 65536;
        else        d = -((-d + 65535) / 65536);
        if (d > 32767)  d = 32767;
        if (d < -32768) d = -32768;
        return int'(d);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic int rnd_sample();
        case ($urandom_range(0, 5))
            0:       return -32768;
            1:       return 32767;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic scramble();
        for (int k = 0; k < N_CH; k++) begin
            sin_in[k*W +: W]   = 16'($urandom);
            cos_in[k*W +: W]   = 16'($urandom);
            ang_in[k*CW +: CW] = 16'($urandom);
        end
    endtask

    task automatic rand_vectors();
        for (int k = 0; k < N_CH; k++) begin
            vs[k] = rnd_sample();
            vc[k] = rnd_sample();
            va[k] = int'($urandom_range(0, 65535));
            sm[k] = 1'b0;
        end
    endtask

    // Drive start with vs/vc/va for one cycle; queue results if it will be accepted.
    task automatic do_start();
        for (int k = 0; k < N_CH; k++) begin
            sin_in[k*W +: W]   = 16'(vs[k]);
            cos_in[k*W +: W]   = 16'(vc[k]);
            ang_in[k*CW +: CW] = 16'(va[k]);
        end
        start = 1'b1;
        if (cyc >= acc_t + 4 + N_CH) begin
            acc_t = cyc;
            for (int k = 0; k < N_CH; k++) begin
                exp_q.push_back({32'(cyc + 4 + k), sm[k], (k == N_CH - 1),
                                 3'(k), 16'(model_err(vs[k], vc[k], va[k]))});
            end
        end else begin
            ov_cyc = cyc + 1;
        end
        step();
        start = 1'b0;
        scramble();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err_valid"}, err_valid, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_err_ch"}, err_ch, 0);
        chk({tag, "_err_data"}, err_data, 0);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin : monitor
        logic [EXP_W-1:0] e;
        bit               eb;
        if (checking && !rst) begin
            eb = (cyc >= acc_t + 1) && (cyc <= acc_t + 3 + N_CH);
            chk("busy", busy, eb);
            chk("overrun", overrun, cyc == ov_cyc);
            while (exp_q.size() > 0 && int'(exp_q[0][52:21]) < cyc) begin
                e = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL err_missing: ch %0d due cycle %0d not seen (cycle %0d)",
                         e[18:16], e[52:21], cyc);
            end
            if (err_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL err_unexpected: ch %0d data %0d expected none (cycle %0d)",
                             err_ch, err_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("err_cycle", cyc, int'(e[52:21]));
                    chk("err_ch", err_ch, e[18:16]);
                    chk("err_data", err_data, $signed(e[15:0]));
                    chk("done", done, e[19]);
                    if (e[20]) chk("near_zero", (err_data >= -2) && (err_data <= 2), 1);
                end
            end else begin
                chk("done_idle", done, 0);
            end
        end
    end

    initial begin : driver
        int t;
        int sb[4] = '{3196, 9102, 13623, 16069};
        int cb[4] = '{16069, 13623, 9102, 3196};

        // reset
        scramble();
        repeat (3) step();
        rst = 1'b0;
        chk_outputs_zero("reset");
        checking = 1'b1;
        step();

        // directed: offset, q2 sign flip, both saturation limits
        vs = '{0, 0, 32767, -32768, 1000};
        vc = '{16384, 16384, -32768, 32767, -2000};
        va = '{16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'h5A5A};
        sm = '{0, 0, 0, 0, 0};
        t = cyc;
        do_start();
        // busy: this start must be rejected
        wait_until(t + 5);
        rand_vectors();
        do_start();
        // first cycle the FSM is idle again: accepted
        for (int qq = 0; qq < 4; qq++) begin
            wait_until(t + 9);
            for (int k = 0; k < 4; k++) begin
                case (qq)
                    0:       begin vs[k] = sb[k];  vc[k] = cb[k];  end
                    1:       begin vs[k] = cb[k];  vc[k] = -sb[k]; end
                    2:       begin vs[k] = -sb[k]; vc[k] = -cb[k]; end
                    default: begin vs[k] = -cb[k]; vc[k] = sb[k];  end
                endcase
                va[k] = (qq << 14) | (k << 12) | 12'h800;
                sm[k] = 1'b1;
            end
            vs[4] = rnd_sample();
            vc[4] = rnd_sample();
            va[4] = int'($urandom_range(0, 65535));
            sm[4] = 1'b0;
            t = cyc;
            do_start();
        end

        // reset in the middle of a sweep
        wait_until(acc_t + 4 + N_CH);
        rand_vectors();
        t = cyc;
        do_start();
        wait_until(t + 3);
        rst = 1'b1;
        exp_q.delete();
        acc_t  = -1000;
        ov_cyc = -1;
        step();
        rst = 1'b0;
        chk_outputs_zero("midrst");
        repeat (12) step();

        // random sweeps with random gaps and occasional rejected starts
        for (int n = 0; n < 20; n++) begin
            wait_until(acc_t + 4 + N_CH + int'($urandom_range(0, 3)));
            rand_vectors();
            t = cyc;
            do_start();
            if ($urandom_range(0, 1) == 1) begin
                wait_until(t + int'($urandom_range(1, 3 + N_CH)));
                rand_vectors();
                do_start();
            end
        end

        wait_until(acc_t + N_CH + 8);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_empty: %0d results outstanding, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
